ram_sized_ctrl: RTL

//  Parametrised byte-addressable big-endian data RAM with byte/half/word

---
 rtl/ram_sized_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ram_sized_ctrl.sv
// ram_sized_ctrl
//   Byte-addressable big-endian data RAM with byte/half/word accesses.
//   The RAM inserts a programmable number of wait states before each access.
//   Completion is signalled by a one-cycle finished pulse.
//   A request is accepted only while idle. Address, direction, size and write
//   data are latched at acceptance, so the inputs may change freely while the
//   access is in progress.
//
// Parameters
//   ADDR_W       byte address width
//   DEPTH        bytes of storage (multiple of 4, at most 1<<ADDR_W)
//   WAIT_STATES  extra cycles inserted before the access (0..15)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   request strobe, sampled only while idle
//   rw        in   1 = read, 0 = write
//   adr       in   byte address
//   data_in   in   write data, right-justified
//   size      in   00 byte, 01 half, 10/11 word
//   data_out  out  read data, zero-extended, right-justified
//   finished  out  one-cycle completion pulse
//   busy      out  high from acceptance until the completion cycle
//   err       out  misalignment pulse alongside finished (optional feature)
//
// Configuration macro
//   RAM_MISALIGN_ABORT_EN
//     When defined, a misaligned half or word access is aborted. The access
//     writes nothing, leaves data_out unchanged, and raises err together
//     with finished.
//     When undefined, the low address bits are forced to zero, the access
//     proceeds, and err is tied low.

module ram_sized_ctrl #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned DEPTH       = 1 << ADDR_W,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              rw,
   input  logic [ADDR_W-1:0] adr,
   input  logic [31:0]       data_in,
   input  logic [1:0]        size,
   output logic [31:0]       data_out,
   output logic              finished,
   output logic              busy,
   output logic              err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {StIdle, StWait, StAccess} state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] adr_q;
   logic              rw_q;
   logic [1:0]        size_q;
   logic [31:0]       wdata_q;

   logic [7:0]        mem [DEPTH];

   logic [ADDR_W-1:0] base;
   logic              abort;
   logic [IDX_W-1:0]  i0, i1, i2, i3;
   logic [31:0]       rdata;

   // Byte index of base+off, wrapped into the storage range.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] b,
                                                 input logic [1:0] off);
      logic [ADDR_W:0] sum;
      sum = {1'b0, b} + {{(ADDR_W - 1){1'b0}}, off};
      return IDX_W'(sum % DEPTH_V);
   endfunction

   // Effective base address and abort decision for the latched request.
   always_comb begin
      base  = adr_q;
      abort = 1'b0;
`ifdef RAM_MISALIGN_ABORT_EN
      abort = size_q[1] ? (adr_q[1:0] != 2'b00) : (size_q[0] & adr_q[0]);
`else
      if (size_q[1]) begin
         base[1:0] = 2'b00;
      end else if (size_q[0]) begin
         base[0] = 1'b0;
      end
`endif
   end

   assign i0 = wrap_idx(base, 2'd0);
   assign i1 = wrap_idx(base, 2'd1);
   assign i2 = wrap_idx(base, 2'd2);
   assign i3 = wrap_idx(base, 2'd3);

   // Big-endian assembly: the lowest address holds the most significant byte.
   always_comb begin
      rdata = {mem[i0], mem[i1], mem[i2], mem[i3]};
      case (size_q)
         2'b00:   rdata = {24'h0, mem[i0]};
         2'b01:   rdata = {16'h0, mem[i0], mem[i1]};
         default: rdata = {mem[i0], mem[i1], mem[i2], mem[i3]};
      endcase
   end

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         adr_q    <= '0;
         rw_q     <= 1'b0;
         size_q   <= 2'b00;
         wdata_q  <= 32'h0;
         data_out <= 32'h0;
         finished <= 1'b0;
         busy     <= 1'b0;
`ifdef RAM_MISALIGN_ABORT_EN
         err      <= 1'b0;
`endif
      end else begin
         finished <= 1'b0;
`ifdef RAM_MISALIGN_ABORT_EN
         err      <= 1'b0;
`endif
         case (state_q)
            StIdle: begin
               if (en) begin
                  adr_q   <= adr;
                  rw_q    <= rw;
                  size_q  <= size;
                  wdata_q <= data_in;
                  cnt_q   <= 4'(WAIT_STATES);
                  busy    <= 1'b1;
                  state_q <= (WAIT_STATES == 0) ? StAccess : StWait;
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 4'd1;
               // Counter reaches zero at this edge: next cycle is the access.
               if (cnt_q <= 4'd1) begin
                  state_q <= StAccess;
               end
            end
            StAccess: begin
               finished <= 1'b1;
               busy     <= 1'b0;
               state_q  <= StIdle;
               if (rw_q && !abort) begin
                  data_out <= rdata;
               end
`ifdef RAM_MISALIGN_ABORT_EN
               err <= abort;
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifndef RAM_MISALIGN_ABORT_EN
   assign err = 1'b0;
`endif

   // Storage is not reset. A write lands only on its access edge, so a
   // reset during the wait phase leaves memory untouched.
   always_ff @(posedge clk) begin
      if (state_q == StAccess && !rw_q && !abort) begin
         case (size_q)
            2'b00: mem[i0] <= wdata_q[7:0];
            2'b01: begin
               mem[i0] <= wdata_q[15:8];
               mem[i1] <= wdata_q[7:0];
            end
            default: begin
               mem[i0] <= wdata_q[31:24];
               mem[i1] <= wdata_q[23:16];
               mem[i2] <= wdata_q[15:8];
               mem[i3] <= wdata_q[7:0];
            end
         endcase
      end
   end

endmodule
